// File: rtl/glb_pkg.sv
// Shared types and helpers for the psum global-buffer write arbiter.
package glb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    localparam int unsigned STAT_W = 16;

    // Width of a beat counter that must hold 0..burst_len inclusive.
    function automatic int unsigned cnt_w(input int unsigned burst_len);
        return $clog2(burst_len + 1);
    endfunction

endpackage

// File: rtl/glb_rr_pick.sv
// Combinational wrap-around first-set search over req, starting at index start.
module glb_rr_pick #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] winner_c,
    output logic             found_c
);

    localparam int unsigned POS_W = IDX_W + 1;

    logic [POS_W-1:0] pos;

    always_comb begin
        winner_c = '0;
        found_c  = 1'b0;
        pos      = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, start} + POS_W'(k);
            if (pos >= POS_W'(N)) begin
                pos = pos - POS_W'(N);
            end
            if (!found_c && req[pos[IDX_W-1:0]]) begin
                found_c  = 1'b1;
                winner_c = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/glb_psum_wr_arbiter.sv
// Burst-locked round-robin arbiter sharing the psum GB write port among PE columns.
// Optional per-column accepted-beat counters when GLB_ARB_STATS_EN is defined.
module glb_psum_wr_arbiter
    import glb_pkg::*;
#(
    parameter int unsigned DATA_BITWIDTH = 16,
    parameter int unsigned ADDR_BITWIDTH = 10,
    parameter int unsigned X_dim         = 3,
    parameter int unsigned BURST_LEN     = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [X_dim-1:0]                 req,
    input  logic [X_dim*ADDR_BITWIDTH-1:0]   addr_in,
    input  logic [X_dim*DATA_BITWIDTH-1:0]   data_in,
    input  logic                             stall,
    output logic [X_dim-1:0]                 grant,
    output logic                             write_en_psum,
    output logic [ADDR_BITWIDTH-1:0]         w_addr_psum,
    output logic [DATA_BITWIDTH-1:0]         w_data_psum,
    output logic                             busy
`ifdef GLB_ARB_STATS_EN
    ,
    output logic [X_dim*STAT_W-1:0]          grant_cnt
`endif
);

    localparam int unsigned IDX_W = (X_dim > 1) ? $clog2(X_dim) : 1;
    localparam int unsigned CNT_W = cnt_w(BURST_LEN);

    arb_state_t         state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   beat_cnt;

    logic                     own_ok;
    logic [IDX_W-1:0]         owner_next;
    logic [IDX_W-1:0]         search_start;
    logic [IDX_W-1:0]         win;
    logic                     found;
    logic [IDX_W-1:0]         sel;
    logic                     xfer;
    logic [ADDR_BITWIDTH-1:0] sel_addr;
    logic [DATA_BITWIDTH-1:0] sel_data;

    // Owner keeps the port while it still requests and has burst budget left.
    always_comb begin
        own_ok       = (state == OWN) && req[owner] && (beat_cnt < CNT_W'(BURST_LEN));
        owner_next   = (owner == IDX_W'(X_dim - 1)) ? '0 : owner + IDX_W'(1);
        search_start = (state == OWN) ? owner_next : rr_ptr;
        sel          = own_ok ? owner : win;
        xfer         = (own_ok || found) && !reset && !stall;
    end

    glb_rr_pick #(
        .N     (X_dim),
        .IDX_W (IDX_W)
    ) u_pick (
        .req      (req),
        .start    (search_start),
        .winner_c (win),
        .found_c  (found)
    );

    always_comb begin
        grant = '0;
        if (xfer) begin
            grant[sel] = 1'b1;
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < X_dim; i++) begin
            if (sel == IDX_W'(i)) begin
                sel_addr = addr_in[i*ADDR_BITWIDTH +: ADDR_BITWIDTH];
                sel_data = data_in[i*DATA_BITWIDTH +: DATA_BITWIDTH];
            end
        end
    end

    // Arbitration state and registered write port; stall freezes everything but write_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            owner         <= '0;
            rr_ptr        <= '0;
            beat_cnt      <= '0;
            write_en_psum <= 1'b0;
            w_addr_psum   <= '0;
            w_data_psum   <= '0;
            busy          <= 1'b0;
        end else begin
            write_en_psum <= xfer;
            if (xfer) begin
                w_addr_psum <= sel_addr;
                w_data_psum <= sel_data;
            end
            if (!stall) begin
                if (own_ok) begin
                    beat_cnt <= beat_cnt + CNT_W'(1);
                    busy     <= 1'b1;
                end else if (found) begin
                    state    <= OWN;
                    owner    <= win;
                    beat_cnt <= CNT_W'(1);
                    busy     <= 1'b1;
                end else begin
                    state  <= IDLE;
                    rr_ptr <= search_start;
                    busy   <= 1'b0;
                end
            end
        end
    end

`ifdef GLB_ARB_STATS_EN
    // Saturating per-column accepted-beat counters.
    always_ff @(posedge clk) begin
        for (int i = 0; i < X_dim; i++) begin
            if (reset) begin
                grant_cnt[i*STAT_W +: STAT_W] <= '0;
            end else if (grant[i] && (grant_cnt[i*STAT_W +: STAT_W] != {STAT_W{1'b1}})) begin
                grant_cnt[i*STAT_W +: STAT_W] <= grant_cnt[i*STAT_W +: STAT_W] + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_glb_psum_wr_arbiter.sv
// Bench for glb_psum_wr_arbiter: directed table, hand sequences, and random run vs. a rule-level model.
module tb_glb_psum_wr_arbiter;

    localparam int X  = 3;
    localparam int B  = 4;
    localparam int AW = 10;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              stall;
    logic [X-1:0]      req;
    logic [X*AW-1:0]   addr_in;
    logic [X*DW-1:0]   data_in;
    logic [X-1:0]      grant;
    logic              write_en_psum;
    logic [AW-1:0]     w_addr_psum;
    logic [DW-1:0]     w_data_psum;
    logic              busy;

    always #5 clk = ~clk;

    glb_psum_wr_arbiter #(
        .DATA_BITWIDTH (DW),
        .ADDR_BITWIDTH (AW),
        .X_dim         (X),
        .BURST_LEN     (B)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .addr_in       (addr_in),
        .data_in       (data_in),
        .stall         (stall),
        .grant         (grant),
        .write_en_psum (write_en_psum),
        .w_addr_psum   (w_addr_psum),
        .w_data_psum   (w_data_psum),
        .busy          (busy)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: who holds the port, how many beats it has used, where the next search starts.
    bit            m_own   = 1'b0;
    int            m_owner = 0;
    int            m_cnt   = 0;
    int            m_ptr   = 0;
    bit            m_we    = 1'b0;
    bit            m_busy  = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_data  = '0;

    typedef struct {
        bit           rst;
        bit           stl;
        logic [X-1:0] rq;
        logic [X-1:0] g;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_start();
        return m_own ? (m_owner + 1) % X : m_ptr;
    endfunction

    function automatic int m_grant(output bit cont);
        int s;
        cont = 1'b0;
        if (reset || stall) return -1;
        if (m_own && req[m_owner] && m_cnt < B) begin
            cont = 1'b1;
            return m_owner;
        end
        s = m_start();
        for (int k = 0; k < X; k++) begin
            if (req[(s + k) % X]) return (s + k) % X;
        end
        return -1;
    endfunction

    task automatic drive(input bit r, input bit s, input logic [X-1:0] q);
        reset = r;
        stall = s;
        req   = q;
        for (int i = 0; i < X; i++) begin
            addr_in[i*AW +: AW] = AW'($urandom);
            data_in[i*DW +: DW] = DW'($urandom);
        end
    endtask

    // One clock: check outputs mid-cycle, then advance the model on the rising edge.
    task automatic cycle(input logic [X-1:0] exp_g, input bit use_exp);
        int           g;
        bit           cont;
        logic [X-1:0] mg;
        @(negedge clk);
        g  = m_grant(cont);
        mg = (g >= 0) ? (X'(1) << g) : '0;
        check("grant_model", 32'(grant), 32'(mg));
        if (use_exp) check("grant_table", 32'(grant), 32'(exp_g));
        check("write_en", 32'(write_en_psum), 32'(m_we));
        check("w_addr", 32'(w_addr_psum), 32'(m_addr));
        check("w_data", 32'(w_data_psum), 32'(m_data));
        check("busy", 32'(busy), 32'(m_busy));
        @(posedge clk);
        if (reset) begin
            m_own = 1'b0; m_owner = 0; m_cnt = 0; m_ptr = 0;
            m_we = 1'b0; m_addr = '0; m_data = '0;
        end else if (stall) begin
            m_we = 1'b0;
        end else if (g >= 0) begin
            m_we   = 1'b1;
            m_addr = addr_in[g*AW +: AW];
            m_data = data_in[g*DW +: DW];
            if (cont) begin
                m_cnt++;
            end else begin
                m_own = 1'b1; m_owner = g; m_cnt = 1;
            end
        end else begin
            m_we  = 1'b0;
            m_ptr = m_start();
            m_own = 1'b0;
        end
        m_busy = m_own;
        #1;
    endtask

    task automatic add(input bit r, input bit s, input logic [X-1:0] q, input logic [X-1:0] g);
        vec_t v;
        v.rst = r; v.stl = s; v.rq = q; v.g = g;
        tbl.push_back(v);
    endtask

    initial begin
        logic [X-1:0] rot;
        drive(1'b1, 1'b0, 3'b111);
        repeat (2) @(posedge clk);
        #1;

        // Reset hold, then full contention rotating in bursts of four.
        add(1, 0, 3'b111, 3'b000);
        add(1, 0, 3'b111, 3'b000);
        for (int k = 0; k < 24; k++) begin
            rot = X'(1) << ((k / B) % X);
            add(0, 0, 3'b111, rot);
        end
        // Owner drops mid-burst, pending column takes over the same cycle.
        add(1, 0, 3'b111, 3'b000);
        add(0, 0, 3'b101, 3'b001);
        add(0, 0, 3'b101, 3'b001);
        add(0, 0, 3'b100, 3'b100);
        add(0, 0, 3'b100, 3'b100);
        add(0, 0, 3'b000, 3'b000);
        add(0, 0, 3'b010, 3'b010);
        // Stall mid-burst, then the remaining two beats before rotating.
        add(1, 0, 3'b000, 3'b000);
        add(0, 0, 3'b010, 3'b010);
        add(0, 0, 3'b010, 3'b010);
        add(0, 1, 3'b010, 3'b000);
        add(0, 1, 3'b010, 3'b000);
        add(0, 1, 3'b010, 3'b000);
        add(0, 0, 3'b110, 3'b010);
        add(0, 0, 3'b110, 3'b010);
        add(0, 0, 3'b110, 3'b100);
        add(0, 0, 3'b110, 3'b100);
        // Stall while idle grants nothing.
        add(1, 0, 3'b000, 3'b000);
        add(0, 1, 3'b111, 3'b000);
        add(0, 0, 3'b111, 3'b001);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].stl, tbl[i].rq);
            cycle(tbl[i].g, 1'b1);
        end

        // Lone requester keeps the port across burst boundaries; writes land one cycle late.
        drive(1'b1, 1'b0, 3'b000);
        cycle(3'b000, 1'b1);
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b0, 3'b010);
            addr_in[1*AW +: AW] = AW'(10 + k);
            cycle(3'b010, 1'b1);
            check("p2_we", 32'(write_en_psum), 32'd1);
            check("p2_addr", 32'(w_addr_psum), 32'(10 + k));
        end
        drive(1'b0, 1'b0, 3'b000);
        cycle(3'b000, 1'b1);
        check("p2_we_off", 32'(write_en_psum), 32'd0);
        check("p2_addr_hold", 32'(w_addr_psum), 32'd15);

        // Reset lands on col2's third beat: beat dropped, restart at col0.
        drive(1'b1, 1'b0, 3'b000);
        cycle(3'b000, 1'b1);
        drive(1'b0, 1'b0, 3'b100);
        cycle(3'b100, 1'b1);
        cycle(3'b100, 1'b1);
        drive(1'b1, 1'b0, 3'b100);
        cycle(3'b000, 1'b1);
        check("p6_drop_we", 32'(write_en_psum), 32'd0);
        check("p6_busy", 32'(busy), 32'd0);
        drive(1'b0, 1'b0, 3'b111);
        cycle(3'b001, 1'b1);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0, X'($urandom));
            cycle('0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
